// File: rtl/alu_issue_dec.sv
// alu_issue_dec: RV32I decode-and-issue stage feeding the 32-bit ALU.
// Decodes one instruction per cycle into an ALU operator and two operands,
// presented through a two-entry skid buffer (main + skid register) so that
// in_ready can be registered without losing throughput.
// Optional feature macro: ALU_DEC_BRANCH_EN (decode BRANCH opcodes; when
// undefined, branches are reported as illegal).
module alu_issue_dec #(
  parameter int D_WIDTH = 32,
  parameter int OP_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [D_WIDTH-1:0] in_pc,
  input  logic [D_WIDTH-1:0] in_rs1_val,
  input  logic [D_WIDTH-1:0] in_rs2_val,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    out_op,
  output logic [D_WIDTH-1:0] out_a,
  output logic [D_WIDTH-1:0] out_b,
  output logic [4:0]         out_rd,
  output logic               out_wb_en,
  output logic               out_illegal
);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(9);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [D_WIDTH-1:0] a;
    logic [D_WIDTH-1:0] b;
    logic [4:0]         rd;
    logic               wb_en;
    logic               illegal;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_idx;
  logic       unused_rs1_idx;

  assign opcode         = in_instr[6:0];
  assign rd_idx         = in_instr[11:7];
  assign funct3         = in_instr[14:12];
  assign funct7         = in_instr[31:25];
  assign unused_rs1_idx = ^in_instr[19:15];

  entry_t dec;

  entry_t main_q;
  entry_t skid_q;
  logic   main_valid_q;
  logic   skid_valid_q;
  logic   in_ready_q;

  // Combinational decode of the presented instruction into an ALU entry.
  always_comb begin
    dec         = '0;
    dec.rd      = rd_idx;
    dec.op      = OP_ADD;
    dec.wb_en   = 1'b1;
    dec.illegal = 1'b0;
    case (opcode)
      OPC_R: begin
        dec.a = in_rs1_val;
        dec.b = in_rs2_val;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  dec.op = OP_ADD;
            3'b001:  dec.op = OP_SLL;
            3'b010:  dec.op = OP_SLT;
            3'b011:  dec.op = OP_SLTU;
            3'b100:  dec.op = OP_XOR;
            3'b101:  dec.op = OP_SRL;
            3'b110:  dec.op = OP_OR;
            default: dec.op = OP_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec.op = OP_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec.op = OP_SRA;
        end else begin
          dec.illegal = 1'b1;
        end
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec.b = D_WIDTH'(in_rs2_val[4:0]);
        end
      end
      OPC_I: begin
        dec.a = in_rs1_val;
        dec.b = D_WIDTH'($signed(in_instr[31:20]));
        case (funct3)
          3'b000: dec.op = OP_ADD;
          3'b010: dec.op = OP_SLT;
          3'b011: dec.op = OP_SLTU;
          3'b100: dec.op = OP_XOR;
          3'b110: dec.op = OP_OR;
          3'b111: dec.op = OP_AND;
          3'b001: begin
            dec.op      = OP_SLL;
            dec.b       = D_WIDTH'(in_instr[24:20]);
            dec.illegal = (funct7 != F7_BASE);
          end
          default: begin
            dec.op      = (funct7 == F7_ALT) ? OP_SRA : OP_SRL;
            dec.b       = D_WIDTH'(in_instr[24:20]);
            dec.illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
          end
        endcase
      end
      OPC_LUI: begin
        dec.a = '0;
        dec.b = D_WIDTH'($signed({in_instr[31:12], 12'b0}));
      end
      OPC_AUIPC: begin
        dec.a = in_pc;
        dec.b = D_WIDTH'($signed({in_instr[31:12], 12'b0}));
      end
      OPC_LOAD: begin
        dec.a = in_rs1_val;
        dec.b = D_WIDTH'($signed(in_instr[31:20]));
      end
      OPC_STORE: begin
        dec.a     = in_rs1_val;
        dec.b     = D_WIDTH'($signed({in_instr[31:25], in_instr[11:7]}));
        dec.wb_en = 1'b0;
      end
      OPC_JAL, OPC_JALR: begin
        dec.a = in_pc;
        dec.b = D_WIDTH'(4);
      end
`ifdef ALU_DEC_BRANCH_EN
      OPC_BRANCH: begin
        dec.a     = in_rs1_val;
        dec.b     = in_rs2_val;
        dec.wb_en = 1'b0;
        case (funct3)
          3'b000, 3'b001: dec.op = OP_SUB;
          3'b100, 3'b101: dec.op = OP_SLT;
          3'b110, 3'b111: dec.op = OP_SLTU;
          default:        dec.illegal = 1'b1;
        endcase
      end
`else
      OPC_BRANCH: begin
        dec.illegal = 1'b1;
      end
`endif
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    if (dec.illegal) begin
      dec.op    = OP_ADD;
      dec.a     = '0;
      dec.b     = '0;
      dec.wb_en = 1'b0;
    end
    if (rd_idx == 5'd0) begin
      dec.wb_en = 1'b0;
    end
  end

  // Skid buffer: main register drives the outputs, skid catches one entry
  // accepted while main is stalled; in_ready is the registered skid-empty flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (flush) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (!main_valid_q || out_ready) begin
      if (skid_valid_q) begin
        main_q       <= skid_q;
        main_valid_q <= 1'b1;
        skid_valid_q <= 1'b0;
        in_ready_q   <= 1'b1;
      end else if (in_valid && in_ready_q) begin
        main_q       <= dec;
        main_valid_q <= 1'b1;
      end else begin
        main_valid_q <= 1'b0;
      end
    end else if (in_valid && in_ready_q) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
      in_ready_q   <= 1'b0;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_op      = main_q.op;
  assign out_a       = main_q.a;
  assign out_b       = main_q.b;
  assign out_rd      = main_q.rd;
  assign out_wb_en   = main_q.wb_en;
  assign out_illegal = main_q.illegal;

endmodule

// File: doc/alu_issue_dec.md
# alu_issue_dec

Decode-and-issue stage feeding the 32-bit ALU. Accepts one RV32I instruction per cycle with its PC and register-file read values, decodes it into the ALU's 4-bit operator code and two operands, and presents them on a registered valid/ready interface. Sits between register read and the ALU. A two-entry skid buffer gives full throughput with registered backpressure.

## Interface
- D_WIDTH, 32, operand/PC width
- OP_W, 4, ALU operator code width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- flush  in  1  synchronous discard of all buffered entries
- in_valid  in  1  instruction present
- in_ready  out  1  stage can accept; registered
- in_instr  in  32  RV32I instruction word
- in_pc  in  D_WIDTH  instruction address
- in_rs1_val  in  D_WIDTH  rs1 value
- in_rs2_val  in  D_WIDTH  rs2 value
- out_valid  out  1  issued op present
- out_ready  in  1  ALU side accepts
- out_op  out  OP_W  operator: 0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and
- out_a, out_b  out  D_WIDTH  ALU operands
- out_rd  out  5  destination register
- out_wb_en  out  1  result is written back
- out_illegal  out  1  undecodable instruction

## Operation
- R-type (0110011): a=rs1, b=rs2; funct3/funct7 to ops 0..9 (sub/sra need funct7=0100000). Shifts use b={27'b0, rs2[4:0]}. Any other funct7 is illegal.
- I-ALU (0010011): a=rs1, b=sign-extended imm[31:20]. No subi. Shifts use b={27'b0, shamt}. imm[11:5] must be 0000000 (slli/srli) or 0100000 (srai); otherwise illegal.
- LUI: a=0, b={instr[31:12],12'b0}, add. AUIPC: same, but a=pc.
- LOAD (0000011): rs1 + I-imm, add, wb_en=1. STORE (0100011): rs1 + S-imm, add, wb_en=0.
- JAL/JALR: a=pc, b=4, add (link value), wb_en=1.
- BRANCH (1100011): a=rs1, b=rs2, wb_en=0. beq/bne use sub; blt/bge use slt; bltu/bgeu use sltu. funct3 010/011 are illegal.
- wb_en is forced to 0 when rd=0.
- Illegal or unknown opcode: out_illegal=1, op=0, a=b=0, wb_en=0. The entry still issues.
- Skid buffer: main register drives outputs; a skid register catches the entry accepted while the main register is stalled.

## Timing
- Reset: out_valid=0, out_op=0, out_a=out_b=0, out_rd=0, out_wb_en=0, out_illegal=0, skid empty, in_ready=1.
- Transfers occur on a rising edge with valid&&ready. Latency is 1 cycle from input accept to out_valid.
- Throughput is 1/cycle while out_ready=1.
- While out_valid && !out_ready, all out_* hold stable.
- Accept while the main register is stalled: the entry goes to skid, and in_ready=0 from the next cycle.
- Main register drains with skid full: skid moves to main, and in_ready=1 next cycle. Order is always preserved.
- Main register drains while a new input is accepted, skid empty: the new entry loads main directly.
- flush=1: both entries are cleared at the edge, and any input presented that cycle is dropped. Next cycle out_valid=0 and in_ready=1. flush has priority over all transfers.
- Reset asserted mid-operation: outputs and state clear immediately to reset values.

## Configuration
- ALU_DEC_BRANCH_EN defined: BRANCH opcodes are decoded as above.
- ALU_DEC_BRANCH_EN undefined: BRANCH opcodes decode as illegal (out_illegal=1, op=0, a=b=0).

## Test plan
- Reset, then issue `add x3,x1,x2` with rs1=5, rs2=7 -> next cycle out_valid=1, op=0, a=5, b=7, rd=3, wb_en=1.
- `srai x5,x6,4` with rs1=0x80000000 -> op=7, a=0x80000000, b=4. `slli` with imm[11:5]=0000001 -> out_illegal=1, op=0, a=b=0.
- `bltu`, rs1=1, rs2=2, macro defined -> op=4, wb_en=0. Macro undefined -> out_illegal=1.
- Hold out_ready=0 and stream 3 instructions. Check in_ready falls after the second accept and outputs stay stable. Then release out_ready and check in-order delivery, one per cycle.
- Fill both entries, then assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed input never appears.
- `auipc x1,0x12345` at pc=0x100 -> op=0, a=0x100, b=0x12345000. `lui x0,1` -> wb_en=0.
